matdet9_seq: RTL
================

Name: matdet9_seq

Overview:
- Sequential controller that computes a 9x9 determinant by first-row cofactor expansion using one shared external matdet8 instance, instead of nine parallel ones.
- Captures a matrix through a valid/ready handshake and walks columns j=0..8.
- For each column it presents minor M(0,j) to the shared 8x8 determinant unit over a req/ack handshake, then accumulates ±a(0,j)*det(M(0,j)).
- Result leaves through a valid/ready handshake.

Parameters:
- DATA_WIDTH, 8, element and result width. All arithmetic wraps modulo 2^DATA_WIDTH, consistent with the mul/add/sub primitives.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  matrix offered.
- in_ready  out  1  controller idle and able to accept.
- a  in  81*DATA_WIDTH  matrix, element (r,c) at a[(r*9+c)*DATA_WIDTH +: DATA_WIDTH]; row 0 is the least significant row.
- minor  out  64*DATA_WIDTH  current minor M(0,j): rows 1..8, columns c≠j, row-major. The first element (row1, lowest kept column) is in the most significant byte, which matches the existing matdet8 hookup.
- minor_req  out  1  minor is valid and stable.
- minor_ack  in  1  minor_det valid for current minor.
- minor_det  in  DATA_WIDTH  determinant of minor from the shared unit.
- det  out  DATA_WIDTH  result.
- det_valid  out  1  result valid.
- det_ready  in  1  consumer accepts result.

Behaviour:
- Clock/reset: one clock. Reset is asynchronous, active-low (rst_n).
- Reset values: state=IDLE, in_ready=1, minor_req=0, det_valid=0, det=0, accumulator=0, column counter=0, captured matrix=0.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, register all 81 elements, clear acc, set j=0, go to RUN.
  - RUN: in_ready=0, minor_req=1 held continuously. minor is driven combinationally from the captured matrix and j, and is stable while j is unchanged. On a clock edge with minor_ack=1:
    - acc <= acc + a(0,j)*minor_det if j even, acc - a(0,j)*minor_det if j odd. Product truncated to DATA_WIDTH before add/sub.
    - if j<8: j<=j+1, stay in RUN.
    - if j==8: det<=updated acc, go to DONE.
  - DONE: det_valid=1, minor_req=0, in_ready=0. det is held stable. On det_valid&det_ready go to IDLE, det_valid<=0. det keeps its last value.
- Ack rules:
  - minor_ack is only meaningful while minor_req=1; it is ignored in IDLE and DONE.
  - Same-cycle ack is legal: ack tied to req with a combinational matdet8 gives one column per cycle.
  - Ack delayed by d cycles after the column's first req cycle gives d+1 cycles per column.
- Latency: det_valid first high 9*(d+1) cycles after the accept edge. With d=0 this is 9 cycles. The IDLE-to-accept turnaround after det handshake costs 1 cycle; no accept in the same cycle as the det handshake.
- Input matrix is used only from the captured register. Changes on a after accept have no effect.
- in_valid while not IDLE: ignored (in_ready=0), no capture.
- Reset asserted mid-RUN or in DONE: immediate return to reset values. A pending minor_ack is discarded, and no det_valid is produced for the aborted matrix.
- Wrap-around: all accumulation mod 2^DATA_WIDTH; no saturation, no overflow flag.

Test Plan:
- Identity 9x9, ack tied to req, det_ready=1 -> det=0x01; det_valid rises exactly 9 cycles after accept, pulses 1 cycle; minor_req high for 9 cycles.
- Identity with rows 0 and 1 swapped -> det=0xFF (−1 mod 256); diag(3,1,...,1) -> det=0x03; diag all 2 -> det=0x00 (512 mod 256).
- Behavioural shared unit acking 3 cycles after each column starts (d=3), with a(0,j)=j+1 and fixed minor_det=1 -> acc=1-2+3-4+5-6+7-8+9=0x05. det_valid at 36 cycles after accept. minor stays stable across each wait, and each column's minor bus is checked against the expected packing.
- Backpressure: det_ready low 5 cycles in DONE -> det, det_valid stable, in_ready=0, new in_valid ignored. On release, handshake completes, in_ready=1 next cycle, and a second matrix is accepted and computed correctly.
- Reset mid-run: assert rst_n=0 after column 4 ack -> all outputs at reset values asynchronously, no det_valid. After release, the identity matrix -> det=0x01 with normal latency.

Source files
------------

// File: rtl/matdet9_seq.sv
// 9x9 determinant by first-row cofactor expansion, time-sharing one external
// 8x8 determinant unit over a req/ack handshake, one column per acknowledge.
module matdet9_seq #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [81*DATA_WIDTH-1:0]   a,
    output logic [64*DATA_WIDTH-1:0]   minor,
    output logic                       minor_req,
    input  logic                       minor_ack,
    input  logic [DATA_WIDTH-1:0]      minor_det,
    output logic [DATA_WIDTH-1:0]      det,
    output logic                       det_valid,
    input  logic                       det_ready
);

    localparam int unsigned N   = 9;
    localparam int unsigned MN  = 8;
    localparam int unsigned CW  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state;
    logic [81*DATA_WIDTH-1:0]  mat;
    logic [DATA_WIDTH-1:0]     acc;
    logic [CW-1:0]             col;

    logic [DATA_WIDTH-1:0]     a0j;
    logic [DATA_WIDTH-1:0]     prod;
    logic [DATA_WIDTH-1:0]     acc_next;

    // Signed cofactor term for the current column; product wraps to DATA_WIDTH.
    always_comb begin
        a0j      = mat[int'(col)*DATA_WIDTH +: DATA_WIDTH];
        prod     = a0j * minor_det;
        acc_next = col[0] ? (acc - prod) : (acc + prod);
    end

    // Minor M(0,col): skip column col, first kept element lands in the top byte.
    always_comb begin
        minor = '0;
        for (int r = 1; r < int'(N); r++) begin
            for (int cc = 0; cc < int'(MN); cc++) begin
                minor[(63 - ((r - 1) * int'(MN) + cc))*DATA_WIDTH +: DATA_WIDTH] =
                    mat[(r * int'(N) + cc + ((cc >= int'(col)) ? 1 : 0))*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            minor_req <= 1'b0;
            det_valid <= 1'b0;
            det       <= '0;
            acc       <= '0;
            col       <= '0;
            mat       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mat       <= a;
                        acc       <= '0;
                        col       <= '0;
                        in_ready  <= 1'b0;
                        minor_req <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (minor_ack) begin
                        acc <= acc_next;
                        if (col == CW'(N - 1)) begin
                            det       <= acc_next;
                            minor_req <= 1'b0;
                            det_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (det_ready) begin
                        det_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
